// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv
// Purpose  : Iterative RV32M multiply/divide unit beside EX (shift-add multiply,
//            restoring divide, one bit per cycle, flushable, one writeback).
//            Optional macro MULDIV_EARLY_OUT_EN: 1-cycle path for trivial ops.
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_valid,
   output logic                  start_ready,
   input  logic [2:0]            funct3,
   input  logic [XLEN-1:0]       operand1,
   input  logic [XLEN-1:0]       operand2,
   input  logic [REG_ADDR_W-1:0] dest_addr,
   input  logic                  flush,
   output logic                  stall,
   output logic                  busy,
   output logic                  regs_write_en,
   output logic [REG_ADDR_W-1:0] regs_write_addr,
   output logic [XLEN-1:0]       regs_write_data
);

   localparam int              CNT_W    = $clog2(XLEN);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
   localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state;
   state_t                state_nx;
   logic [CNT_W-1:0]      counter;
   logic [2:0]            op;
   logic [REG_ADDR_W-1:0] rd;
   logic                  neg_res;
   logic [XLEN-1:0]       acc_hi;
   logic [XLEN-1:0]       acc_lo;
   logic [XLEN-1:0]       opb;
   logic [XLEN-1:0]       result;

   // Operand decode for the accepting cycle
   logic                  accept;
   logic                  is_div;
   logic                  signed1;
   logic                  signed2;
   logic                  sgn1;
   logic                  sgn2;
   logic [XLEN-1:0]       mag1;
   logic [XLEN-1:0]       mag2;
   logic                  fast;
   logic [XLEN-1:0]       fast_result;

   // Iteration datapath
   logic [XLEN:0]         mul_sum;
   logic [XLEN:0]         div_shift;
   logic [XLEN:0]         div_trial;
   logic [XLEN-1:0]       step_hi;
   logic [XLEN-1:0]       step_lo;
   logic [2*XLEN-1:0]     prod;
   logic [2*XLEN-1:0]     prod_s;
   logic [XLEN-1:0]       quot_s;
   logic [XLEN-1:0]       rem_s;
   logic [XLEN-1:0]       calc_result;

   assign accept  = start_valid && start_ready;
   assign is_div  = funct3[2];
   assign signed1 = funct3[2] ? !funct3[0] : (funct3[1:0] != 2'b11);
   assign signed2 = funct3[2] ? !funct3[0] : !funct3[1];
   assign sgn1    = signed1 && operand1[XLEN-1];
   assign sgn2    = signed2 && operand2[XLEN-1];
   assign mag1    = sgn1 ? (~operand1 + 1'b1) : operand1;
   assign mag2    = sgn2 ? (~operand2 + 1'b1) : operand2;

   // Ops whose result is known at issue skip the iteration entirely
   always_comb begin
      fast        = 1'b0;
      fast_result = '0;
      if (is_div) begin
         if (operand2 == '0) begin
            fast        = 1'b1;
            fast_result = funct3[1] ? operand1 : '1;
         end else if (signed1 && (operand1 == MIN_INT) && (operand2 == '1)) begin
            fast        = 1'b1;
            fast_result = funct3[1] ? '0 : operand1;
         end
`ifdef MULDIV_EARLY_OUT_EN
         else if (mag2 > mag1) begin
            fast        = 1'b1;
            fast_result = funct3[1] ? operand1 : '0;
         end
      end else if (operand2 == '0) begin
         fast        = 1'b1;
         fast_result = '0;
      end
`else
      end
`endif
   end

   // One iteration step: multiplier consumed LSB-first, dividend MSB-first
   always_comb begin
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
      div_shift = {acc_hi, acc_lo[XLEN-1]};
      div_trial = div_shift - {1'b0, opb};
      if (op[2]) begin
         if (!div_trial[XLEN]) begin
            step_hi = div_trial[XLEN-1:0];
            step_lo = {acc_lo[XLEN-2:0], 1'b1};
         end else begin
            step_hi = div_shift[XLEN-1:0];
            step_lo = {acc_lo[XLEN-2:0], 1'b0};
         end
      end else begin
         step_hi = mul_sum[XLEN:1];
         step_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
      end
   end

   // Sign fix-up applied to the values produced by the final step
   always_comb begin
      prod   = {step_hi, step_lo};
      prod_s = neg_res ? (~prod + 1'b1) : prod;
      quot_s = neg_res ? (~step_lo + 1'b1) : step_lo;
      rem_s  = neg_res ? (~step_hi + 1'b1) : step_hi;
      case (op)
         3'b000:                 calc_result = prod_s[XLEN-1:0];
         3'b001, 3'b010, 3'b011: calc_result = prod_s[2*XLEN-1:XLEN];
         3'b100, 3'b101:         calc_result = quot_s;
         default:                calc_result = rem_s;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      start_ready   = 1'b0;
      stall         = 1'b0;
      busy          = (state != IDLE);
      regs_write_en = 1'b0;
      case (state)
         IDLE: begin
            start_ready = !flush;
            stall       = start_valid && !flush;
            if (start_valid && !flush) begin
               state_nx = fast ? DONE : CALC;
            end
         end
         CALC: begin
            stall = 1'b1;
            if (flush) begin
               state_nx = IDLE;
            end else if (counter == LAST_CNT) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            regs_write_en = !flush;
            state_nx      = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         counter <= '0;
         op      <= '0;
         rd      <= '0;
         neg_res <= 1'b0;
         acc_hi  <= '0;
         acc_lo  <= '0;
         opb     <= '0;
         result  <= '0;
      end else if (accept) begin
         counter <= '0;
         op      <= funct3;
         rd      <= dest_addr;
         neg_res <= (is_div && funct3[1]) ? sgn1 : (sgn1 ^ sgn2);
         acc_hi  <= '0;
         acc_lo  <= is_div ? mag1 : mag2;
         opb     <= is_div ? mag2 : mag1;
         result  <= fast_result;
      end else if (state == CALC) begin
         counter <= counter + 1'b1;
         acc_hi  <= step_hi;
         acc_lo  <= step_lo;
         if (counter == LAST_CNT) begin
            result <= calc_result;
         end
      end
   end

   assign regs_write_addr = regs_write_en ? rd : '0;
   assign regs_write_data = regs_write_en ? result : '0;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_muldiv
// Purpose  : Self-checking bench for ex_muldiv: directed literal cases plus
//            randomized ops/flushes against a behavioural arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv;

   localparam int          XLEN     = 32;
   localparam int          RW       = 5;
   localparam int          FULL_LAT = XLEN + 1;
   localparam logic [31:0] MIN_INT  = 32'h8000_0000;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start_valid;
   logic          start_ready;
   logic [2:0]    funct3;
   logic [31:0]   operand1;
   logic [31:0]   operand2;
   logic [RW-1:0] dest_addr;
   logic          flush;
   logic          stall;
   logic          busy;
   logic          regs_write_en;
   logic [RW-1:0] regs_write_addr;
   logic [31:0]   regs_write_data;

   ex_muldiv #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start_valid     (start_valid),
      .start_ready     (start_ready),
      .funct3          (funct3),
      .operand1        (operand1),
      .operand2        (operand2),
      .dest_addr       (dest_addr),
      .flush           (flush),
      .stall           (stall),
      .busy            (busy),
      .regs_write_en   (regs_write_en),
      .regs_write_addr (regs_write_addr),
      .regs_write_data (regs_write_data)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Model of the single outstanding operation
   bit            pend = 1'b0;
   int            pend_acc;
   int            pend_lat;
   logic [RW-1:0] pend_rd;
   logic [31:0]   pend_data;
   bit            pend_lit = 1'b0;
   logic [31:0]   pend_lit_data;
   int            pend_lit_lat;
   bit            lit_on = 1'b0;
   logic [31:0]   lit_data;
   int            lit_lat;
   bit            acc_flag = 1'b0;
   bit            rand_phase = 1'b0;
   bit            mon_was_pend;
   int            mon_age;
   bit            mon_exp_we;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
      int          ia;
      int          ib;
      longint      sa;
      longint      sb;
      longint      ua;
      longint      ub;
      logic [63:0] p;
      ia = a;
      ib = b;
      sa = ia;
      sb = ib;
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      case (f)
         3'd0: begin p = 64'(sa * sb); return p[31:0]; end
         3'd1: begin p = 64'(sa * sb); return p[63:32]; end
         3'd2: begin p = 64'(sa * ub); return p[63:32]; end
         3'd3: begin p = 64'(ua * ub); return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == MIN_INT && b == 32'hFFFF_FFFF) return a;
            return 32'(ia / ib);
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            return a / b;
         end
         3'd6: begin
            if (b == 0) return a;
            if (a == MIN_INT && b == 32'hFFFF_FFFF) return 32'd0;
            return 32'(ia % ib);
         end
         default: begin
            if (b == 0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic bit ref_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      int     ia;
      int     ib;
      longint ma;
      longint mb;
      ia = a;
      ib = b;
      if (f[2]) begin
         if (b == 0) return 1'b1;
         if (!f[0] && a == MIN_INT && b == 32'hFFFF_FFFF) return 1'b1;
         if (!f[0]) begin
            ma = (ia < 0) ? -longint'(ia) : longint'(ia);
            mb = (ib < 0) ? -longint'(ib) : longint'(ib);
         end else begin
            ma = longint'({32'b0, a});
            mb = longint'({32'b0, b});
         end
`ifdef MULDIV_EARLY_OUT_EN
         return mb > ma;
`else
         return (mb > ma) && 1'b0;
`endif
      end
`ifdef MULDIV_EARLY_OUT_EN
      return b == 0;
`else
      return 1'b0;
`endif
   endfunction

   // Compare process: every cycle, all outputs against the model
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         check("rst_busy", busy, 0);
         check("rst_we", regs_write_en, 0);
         check("rst_waddr", regs_write_addr, 0);
         check("rst_wdata", regs_write_data, 0);
         check("rst_stall", stall, start_valid && !flush);
         check("rst_ready", start_ready, !flush);
         pend = 1'b0;
      end else begin
         mon_was_pend = pend;
         mon_age      = cyc - pend_acc;
         mon_exp_we   = pend && (mon_age == pend_lat) && !flush;
         check("ready", start_ready, !pend && !flush);
         check("busy", busy, pend);
         check("stall", stall, pend ? (mon_age < pend_lat) : (start_valid && !flush));
         check("we", regs_write_en, mon_exp_we);
         check("waddr", regs_write_addr, mon_exp_we ? pend_rd : '0);
         check("wdata", regs_write_data, mon_exp_we ? pend_data : '0);
         if (pend && pend_lit && regs_write_en) begin
            check("lit_data", regs_write_data, pend_lit_data);
            check("lit_latency", mon_age, pend_lit_lat);
         end
         if (pend && (mon_age >= pend_lat || flush)) pend = 1'b0;
         if (!mon_was_pend && start_valid && !flush) begin
            pend          = 1'b1;
            pend_acc      = cyc;
            pend_lat      = ref_fast(funct3, operand1, operand2) ? 1 : FULL_LAT;
            pend_rd       = dest_addr;
            pend_data     = ref_result(funct3, operand1, operand2);
            pend_lit      = lit_on;
            pend_lit_data = lit_data;
            pend_lit_lat  = lit_lat;
            lit_on        = 1'b0;
            acc_flag      = 1'b1;
         end
      end
   end

   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [RW-1:0] rd);
      acc_flag    = 1'b0;
      funct3      = f;
      operand1    = a;
      operand2    = b;
      dest_addr   = rd;
      start_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         #1;
         if (acc_flag) break;
      end
      if (!acc_flag) begin
         tests++;
         fails++;
         $display("FAIL accept_timeout: got no accept, expected accept (cycle %0d)", cyc);
      end
      start_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100; i++) begin
         if (!pend) break;
         @(posedge clk);
         #1;
      end
      if (pend) begin
         tests++;
         fails++;
         $display("FAIL idle_timeout: got pending op, expected idle (cycle %0d)", cyc);
      end
   endtask

   task automatic directed(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [RW-1:0] rd, input logic [31:0] exp_data, input int exp_lat);
      lit_on   = 1'b1;
      lit_data = exp_data;
      lit_lat  = exp_lat;
      issue(f, a, b, rd);
      wait_idle();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return 32'hFFFF_FFFF;
         3:       return MIN_INT;
         4:       return 32'($urandom_range(0, 300));
         5:       return -32'($urandom_range(1, 300));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_phase) flush = ($urandom_range(0, 39) == 0);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish by 2000000");
      $fatal(1);
   end

   initial begin
      rst_n       = 1'b0;
      start_valid = 1'b0;
      flush       = 1'b0;
      funct3      = 3'd0;
      operand1    = '0;
      operand2    = '0;
      dest_addr   = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      directed(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 33);
      directed(3'd1, MIN_INT, MIN_INT, 5'd6, 32'h4000_0000, 33);
      directed(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 33);
      directed(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd8, 32'hFFFF_FFFF, 33);
      directed(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD, 33);
      directed(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF, 33);
      directed(3'd5, 32'd100, 32'd7, 5'd11, 32'd14, 33);
      directed(3'd7, 32'd100, 32'd7, 5'd12, 32'd2, 33);
      directed(3'd5, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF, 1);
      directed(3'd6, 32'd5, 32'd0, 5'd14, 32'd5, 1);
      directed(3'd4, MIN_INT, 32'hFFFF_FFFF, 5'd15, MIN_INT, 1);
      directed(3'd6, MIN_INT, 32'hFFFF_FFFF, 5'd16, 32'd0, 1);
`ifdef MULDIV_EARLY_OUT_EN
      directed(3'd0, 32'h1234, 32'd0, 5'd17, 32'd0, 1);
`else
      directed(3'd0, 32'h1234, 32'd0, 5'd17, 32'd0, 33);
`endif

      // Flush in the tenth CALC cycle: op dropped, ready again next cycle
      issue(3'd0, 32'h1357, 32'h2468, 5'd18);
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      wait_idle();

      // Flush in DONE of a 1-cycle op suppresses the write
      issue(3'd5, 32'd9, 32'd0, 5'd19);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      wait_idle();

      // start_valid under flush is ignored, then accepted once flush drops
      flush       = 1'b1;
      funct3      = 3'd7;
      operand1    = 32'd77;
      operand2    = 32'd10;
      dest_addr   = 5'd20;
      start_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      flush = 1'b0;
      issue(3'd7, 32'd77, 32'd10, 5'd20);
      wait_idle();

      // Asynchronous reset mid-CALC
      issue(3'd4, 32'd1000, 32'd3, 5'd21);
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Back-to-back randomized ops with sporadic flushes
      rand_phase = 1'b1;
      for (int n = 0; n < 200; n++) begin
         issue(3'($urandom_range(0, 7)), rand_operand(), rand_operand(),
               RW'($urandom_range(0, 31)));
      end
      rand_phase = 1'b0;
      flush      = 1'b0;
      wait_idle();
      repeat (3) @(posedge clk);
      #1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
